// File: rtl/cla_seq_ctrl.sv
// Sequential W-bit adder: one N-bit carry-lookahead slice reused
// over K = W/N cycles, LSB slice first, with valid/ready handshakes.

module cla_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  localparam int G = N / 4;

  logic       c;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] k;
  logic       gg;

  // 4-bit lookahead groups, group carries rippled between them
  always_comb begin
    c  = ci;
    s  = '0;
    g  = '0;
    p  = '0;
    k  = '0;
    gg = 1'b0;
    for (int i = 0; i < G; i++) begin
      g    = a[i*4 +: 4] & b[i*4 +: 4];
      p    = a[i*4 +: 4] ^ b[i*4 +: 4];
      k[0] = c;
      k[1] = g[0] | (p[0] & c);
      k[2] = g[1] | (p[1] & g[0])
           | (p[1] & p[0] & c);
      k[3] = g[2] | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c);
      gg   = g[3] | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
      k[4] = gg | ((&p) & c);
      s[i*4 +: 4] = p ^ k[3:0];
      c    = k[4];
    end
    co = c;
  end

endmodule

module cla_seq_ctrl #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         busy
);

  localparam int K  = W / N;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          cy_q;
  logic [IW-1:0] idx;
  logic          last;
  logic [N-1:0]  sl_a;
  logic [N-1:0]  sl_b;
  logic [N-1:0]  sl_s;
  logic          sl_co;

  assign last = (idx == IW'(K - 1));
  assign sl_a = a_q[idx*N +: N];
  assign sl_b = b_q[idx*N +: N];

  cla_n #(.N(N)) u_cla (
    .a  (sl_a),
    .b  (sl_b),
    .ci (cy_q),
    .s  (sl_s),
    .co (sl_co)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand capture and one slice of the sum per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cy_q  <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q  <= a;
      b_q  <= b;
      cy_q <= c_in;
      idx  <= '0;
    end else if (state == RUN) begin
      sum[idx*N +: N] <= sl_s;
      cy_q            <= sl_co;
      if (last) c_out <= sl_co;
      else      idx   <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Randomized bench for cla_seq_ctrl against an arithmetic model,
// W=32 main instance plus a single-slice W=8 instance.

module tb_cla_seq_ctrl;

  localparam int N = 8;
  localparam int W = 32;
  localparam int K = W / N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  logic         v1 = 1'b0;
  logic         r1;
  logic [7:0]   a1 = '0;
  logic [7:0]   b1 = '0;
  logic         ci1 = 1'b0;
  logic         ov1;
  logic         or1 = 1'b0;
  logic [7:0]   s1;
  logic         co1;
  logic         bz1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_seq_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
  );

  cla_seq_ctrl #(.N(8), .W(8)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(r1),
    .a(a1), .b(b1), .c_in(ci1),
    .out_valid(ov1), .out_ready(or1),
    .sum(s1), .c_out(co1), .busy(bz1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb_v,
                        input logic tci,
                        input int hold,
                        input bit junk);
    logic [W:0] ref_v;
    int n;
    ref_v = {1'b0, ta} + {1'b0, tb_v} + (W+1)'(tci);
    chk("idle_ready", in_ready, 1);
    a = ta; b = tb_v; c_in = tci; in_valid = 1'b1;
    @(posedge clk); #1;
    if (junk) begin
      a = 32'hDEADBEEF; b = $urandom; c_in = 1'b1;
    end else begin
      in_valid = 1'b0; a = $urandom; b = $urandom;
    end
    chk("run_busy", busy, 1);
    chk("run_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < K + 4) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, K);
    chk("sum", sum, ref_v[W-1:0]);
    chk("c_out", c_out, ref_v[W]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, ref_v[W-1:0]);
      chk("hold_cout", c_out, ref_v[W]);
      chk("hold_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_ready", in_ready, 1);
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("retain_sum", sum, ref_v[W-1:0]);
    chk("retain_cout", c_out, ref_v[W]);
  endtask

  task automatic run_k1(input logic [7:0] ta,
                        input logic [7:0] tb_v,
                        input logic tci);
    logic [8:0] ref_v;
    int n;
    ref_v = {1'b0, ta} + {1'b0, tb_v} + 9'(tci);
    chk("k1_ready", r1, 1);
    a1 = ta; b1 = tb_v; ci1 = tci; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    n = 1;
    while (!ov1 && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    chk("k1_latency", n, 2);
    chk("k1_sum", s1, ref_v[7:0]);
    chk("k1_cout", co1, ref_v[8]);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    chk("k1_post_ready", r1, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_k1_ready", r1, 1);
    rst = 1'b0;

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    run_op(32'h12345678, 32'h11111111, 1'b1, 3, 1'b0);
    run_op(32'h00000005, 32'h00000007, 1'b0, 1, 1'b1);
    run_op(32'h00000000, 32'h00000000, 1'b1, 0, 1'b0);
    run_op(32'h80000000, 32'h80000000, 1'b1, 2, 1'b0);

    // reset while the third slice is being added
    a = 32'hFFFF00FF; b = 32'h0F0F0F0F; c_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_sum", sum, 0);
    chk("abort_cout", c_out, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", out_valid, 0);
    end

    for (int i = 0; i < 30; i++) begin
      run_op($urandom, $urandom, 1'($urandom),
             int'($urandom_range(0, 3)),
             1'($urandom));
    end
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 1'b0);

    run_k1(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_k1(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
